detect_sched: RTL

Round-robin scheduler that shares a single serial "1101" Mealy sequence detector among NREQ parallel requesters. A granted requester's WIDTH-bit word is captured, serialized MSB-first into the detector (one bit per clock), and the number of matches is returned with a one-cycle done strobe. The block sits between the bus-side requesters and the detector datapath; only one word is in flight at a time.

---
 rtl/detect_sched_if.sv | 25 ++
 rtl/detect_sched.sv | 139 +++++++++++++
 2 files changed

// File: rtl/detect_sched_if.sv
// Bus-side bundle for detect_sched: requester words in; grant, status and match count out.
interface detect_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  hit;
  logic                  done;
  logic [CW-1:0]         count;

  modport master (
    output req, data,
    input  grant, busy, hit, done, count
  );

  modport slave (
    input  req, data,
    output grant, busy, hit, done, count
  );
endinterface

// File: rtl/detect_sched.sv
// Round-robin share of one serial "1101" Mealy detector among NREQ requesters.
// DETECT_OVERLAP_EN selects overlapping match counting; undefined gives non-overlapping.
module detect_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           n_rst,
  detect_sched_if.slave bus
);
  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [1:0] {DetS0, DetS1, DetS11, DetS110} det_e;

`ifdef DETECT_OVERLAP_EN
  localparam det_e DetAfterMatch = DetS1;
`else
  localparam det_e DetAfterMatch = DetS0;
`endif

  state_e          state_q, state_d;
  det_e            det_q, det_d, det_step;
  logic [PW-1:0]   ptr_q, ptr_d, sel_q, sel_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]   bit_q, bit_d, count_q, count_d;
  logic            hit_q, hit_d;
  logic            match;

  logic [WIDTH-1:0] words [NREQ];
  for (genvar k = 0; k < NREQ; k++) begin : g_words
    assign words[k] = bus.data[k*WIDTH +: WIDTH];
  end

  // First requesting index at or after ptr, wrapping modulo NREQ.
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW:0]   cand;
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!win_found && bus.req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    match    = 1'b0;
    det_step = DetS0;
    unique case (det_q)
      DetS0:   det_step = shreg_q[WIDTH-1] ? DetS1  : DetS0;
      DetS1:   det_step = shreg_q[WIDTH-1] ? DetS11 : DetS0;
      DetS11:  det_step = shreg_q[WIDTH-1] ? DetS11 : DetS110;
      DetS110: begin
        match    = shreg_q[WIDTH-1];
        det_step = shreg_q[WIDTH-1] ? DetAfterMatch : DetS0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    det_d   = det_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    count_d = count_q;
    hit_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          sel_d            = win_idx;
          shreg_d          = words[win_idx];
          bit_d            = '0;
          count_d          = '0;
          det_d            = DetS0;
          state_d          = StShift;
        end
      end
      StShift: begin
        det_d   = det_step;
        hit_d   = match;
        if (match && (count_q != '1)) count_d = count_q + 1'b1;
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        bit_d   = bit_q + 1'b1;
        if (bit_q == CW'(WIDTH - 1)) state_d = StDone;
      end
      StDone: begin
        grant_d = '0;
        ptr_d   = (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= StIdle;
      det_q   <= DetS0;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      count_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      count_q <= count_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = (state_q != StIdle);
  assign bus.hit   = hit_q;
  assign bus.done  = (state_q == StDone);
  assign bus.count = count_q;

endmodule
